// File: rtl/anim_frame_seq.sv
// anim_frame_seq: free-running / one-shot / ping-pong frame index sequencer
// for a 7-segment animation. A prescaler divides clk by DIV to produce
// frame advances while running; the sequence can be paused, single-stepped
// and resumed.
//
// Ports:
//   clk     - sole clock, all state on rising edge
//   rst_n   - asynchronous active-low reset
//   start   - start / resume request
//   stop    - pause request (wins over start)
//   step    - single-frame manual advance (IDLE/HOLD only)
//   mode    - 00 loop, 01 one-shot, 10 ping-pong, 11 loop
//   frame   - registered frame index 0..31
//   running - registered, high while in RUN
//   done    - one-cycle pulse on one-shot completion
//   wrap    - one-cycle pulse on loop wrap or ping-pong reversal
module anim_frame_seq #(
  parameter int unsigned DIV  = 12500000,
  parameter int unsigned DIVW = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic [1:0] mode,
  output logic [4:0] frame,
  output logic       running,
  output logic       done,
  output logic       wrap
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_e;

  localparam logic [DIVW-1:0] PRESC_LAST = DIVW'(DIV - 1);

  state_e          state_q, state_d;
  logic [4:0]      frame_q, frame_d;
  logic [DIVW-1:0] presc_q, presc_d;
  logic            down_q,  down_d;    // ping-pong direction, 0 = up
  logic [1:0]      mode_q,  mode_d;    // mode latched on entry to RUN
  logic            running_q, done_q, wrap_q;
  logic            done_d, wrap_d;

  logic            resume;
  logic            do_adv;
  logic [4:0]      adv_frame;
  logic            adv_down;
  logic            adv_wrap;
  logic            adv_done;

  // stop always wins over start, so a combined request never leaves IDLE/HOLD
  assign resume = start & ~stop;

  // Result of one frame advance under the latched mode, shared by the
  // prescaler-driven and the manual-step paths.
  always_comb begin
    adv_frame = frame_q;
    adv_down  = down_q;
    adv_wrap  = 1'b0;
    adv_done  = 1'b0;
    case (mode_q)
      2'b01: begin
        if (frame_q == 5'd31) adv_done  = 1'b1;
        else                  adv_frame = frame_q + 5'd1;
      end
      2'b10: begin
        if (!down_q) begin
          if (frame_q == 5'd31) begin
            adv_down  = 1'b1;
            adv_frame = 5'd30;
            adv_wrap  = 1'b1;
          end else begin
            adv_frame = frame_q + 5'd1;
          end
        end else begin
          if (frame_q == 5'd0) begin
            adv_down  = 1'b0;
            adv_frame = 5'd1;
            adv_wrap  = 1'b1;
          end else begin
            adv_frame = frame_q - 5'd1;
          end
        end
      end
      default: begin
        adv_frame = frame_q + 5'd1;
        adv_wrap  = (frame_q == 5'd31);
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    presc_d = presc_q;
    down_d  = down_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    do_adv  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (resume) begin
          state_d = S_RUN;
          presc_d = '0;
          mode_d  = mode;
        end else if (step && !start) begin
          do_adv = 1'b1;
        end
      end
      S_RUN: begin
        // stop takes priority over an advance due in the same cycle
        if (stop) begin
          state_d = S_HOLD;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          do_adv  = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_HOLD: begin
        // prescaler keeps its held value so the resumed frame is not lengthened
        if (resume) begin
          state_d = S_RUN;
        end else if (step) begin
          do_adv = 1'b1;
        end
      end
      S_DONE: begin
        if (resume) begin
          state_d = S_RUN;
          frame_d = '0;
          down_d  = 1'b0;
          presc_d = '0;
          mode_d  = mode;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_adv) begin
      frame_d = adv_frame;
      down_d  = adv_down;
      wrap_d  = adv_wrap;
      done_d  = adv_done;
      if (adv_done) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      presc_q   <= '0;
      down_q    <= 1'b0;
      mode_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      presc_q   <= presc_d;
      down_q    <= down_d;
      mode_q    <= mode_d;
      running_q <= (state_d == S_RUN);
      done_q    <= done_d;
      wrap_q    <= wrap_d;
    end
  end

  assign frame   = frame_q;
  assign running = running_q;
  assign done    = done_q;
  assign wrap    = wrap_q;

endmodule
